// File: rtl/pe_feeder.sv
// pe_feeder: job sequencer in front of a pe_core MAC.
// A job clears the core accumulator for one cycle, streams K operand pairs
// through a valid/ready handshake, waits out the core pipeline for four
// cycles, then captures the core result and pulses done.
module pe_feeder #(
  parameter int W_IN  = 8,
  parameter int W_ACC = 24,
  parameter int W_LEN = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [W_LEN-1:0]        len,
  input  logic                    relu,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [W_IN-1:0]         op_a,
  input  logic signed [W_IN-1:0]  op_b,
  output logic                    pe_en,
  output logic                    mode_sel,
  output logic                    reg_reset,
  output logic [W_IN-1:0]         a_mul,
  output logic signed [W_IN-1:0]  b_mul,
  input  logic signed [W_ACC-1:0] pe_results,
  output logic                    busy,
  output logic                    done,
  output logic signed [W_ACC-1:0] result
);

  // Cycles spent waiting for the core pipeline to settle after the last term.
  localparam int DRAIN_CYC = 4;

  typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, DRAIN} state_t;

  state_t           state;
  logic [W_LEN-1:0] len_q;
  logic             relu_q;
  logic [W_LEN-1:0] term_cnt;
  logic [1:0]       drain_cnt;
  logic             hs;
  logic             last_term;

  // Operands pass straight through; the core ignores them unless pe_en is high.
  assign a_mul = op_a;
  assign b_mul = op_b;

  // A term is issued whenever the feeder is ready and the source has a pair.
  assign hs        = op_ready & op_valid;
  assign pe_en     = hs;
  assign last_term = (term_cnt == len_q - W_LEN'(1));

  assign busy     = (state != IDLE);
  assign mode_sel = relu_q;

  // Job sequencing FSM with registered control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      len_q     <= '0;
      relu_q    <= 1'b0;
      term_cnt  <= '0;
      drain_cnt <= '0;
      op_ready  <= 1'b0;
      reg_reset <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Zero-length jobs are dropped without leaving IDLE.
          if (start && (len != '0)) begin
            state     <= CLEAR;
            len_q     <= len;
            relu_q    <= relu;
            term_cnt  <= '0;
            reg_reset <= 1'b1;
          end
        end
        CLEAR: begin
          state     <= ISSUE;
          reg_reset <= 1'b0;
          op_ready  <= 1'b1;
        end
        ISSUE: begin
          if (hs) begin
            // Counter stops at len_q, so it never wraps even for the max job.
            term_cnt <= term_cnt + W_LEN'(1);
            if (last_term) begin
              state     <= DRAIN;
              op_ready  <= 1'b0;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'(DRAIN_CYC - 1)) begin
            state  <= IDLE;
            result <= pe_results;
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: a simple pe_core stand-in plus a cycle-timeline model
// of job behaviour (start accepted -> clear next cycle -> issue window ->
// done five cycles after the K-th issued term, result = (ReLU of) dot product).
module tb_pe_feeder;

  localparam int W_IN = 8, W_ACC = 24, W_LEN = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic [W_LEN-1:0] len;
  logic relu;
  logic op_valid;
  logic op_ready;
  logic [W_IN-1:0] op_a;
  logic signed [W_IN-1:0] op_b;
  logic pe_en, mode_sel, reg_reset;
  logic [W_IN-1:0] a_mul;
  logic signed [W_IN-1:0] b_mul;
  logic signed [W_ACC-1:0] pe_results;
  logic busy, done;
  logic signed [W_ACC-1:0] result;

  pe_feeder #(.W_IN(W_IN), .W_ACC(W_ACC), .W_LEN(W_LEN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .relu(relu),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pe_en(pe_en), .mode_sel(mode_sel), .reg_reset(reg_reset),
    .a_mul(a_mul), .b_mul(b_mul), .pe_results(pe_results),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pe_core stand-in: registered product, accumulator cleared by reg_reset,
  // optional ReLU on the output. Not reset by reset_n, so stale partial sums
  // survive an aborted job unless the feeder clears them.
  logic signed [W_ACC-1:0] acc = '0;
  logic signed [W_ACC-1:0] p1 = '0;
  logic e1 = 1'b0;
  always @(posedge clk) begin
    e1 <= pe_en;
    p1 <= $signed({1'b0, a_mul}) * b_mul;
    if (reg_reset) acc <= '0;
    else if (e1)   acc <= acc + p1;
  end
  assign pe_results = (mode_sel && acc < 0) ? '0 : acc;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Timeline model state.
  bit     m_active = 0;
  bit     m_relu = 0;
  int     m_clr = -10;
  int     m_k = 0;
  int     m_terms = 0;
  int     m_done_cyc = -1;
  longint m_sum = 0;
  longint m_pend = 0;
  longint m_res = 0;

  // Observation log used by literal checks.
  int pe_first = -1, pe_last = -1, rr_cyc = -1, done_cnt = 0;

  // Model step and per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    bit e_rr, e_rdy, e_en, e_done;
    if (!reset_n) begin
      m_active = 0; m_relu = 0; m_res = 0; m_done_cyc = -1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_op_ready", op_ready, 0);
      chk("rst_pe_en", pe_en, 0);
      chk("rst_reg_reset", reg_reset, 0);
      chk("rst_mode_sel", mode_sel, 0);
    end else begin
      if (m_active && cyc == m_done_cyc) begin
        m_active = 0;
        m_res = m_pend;
      end
      e_done = (cyc == m_done_cyc);
      e_rr   = m_active && (cyc == m_clr);
      e_rdy  = m_active && (cyc > m_clr) && (m_terms < m_k);
      e_en   = e_rdy && op_valid;
      chk("busy", busy, m_active);
      chk("done", done, e_done);
      chk("result", result, m_res);
      chk("reg_reset", reg_reset, e_rr);
      chk("op_ready", op_ready, e_rdy);
      chk("pe_en", pe_en, e_en);
      chk("mode_sel", mode_sel, m_relu);
      chk("a_mul", a_mul, op_a);
      chk("b_mul", b_mul, op_b);
      if (e_en) begin
        m_sum += longint'(op_a) * longint'(op_b);
        m_terms++;
        if (m_terms == m_k) begin
          m_done_cyc = cyc + 5;
          m_pend = (m_relu && m_sum < 0) ? 0 : m_sum;
        end
      end
      if (!m_active && start && len != 0) begin
        m_active = 1; m_relu = relu; m_clr = cyc + 1; m_k = int'(len);
        m_terms = 0; m_sum = 0;
      end
    end
    if (pe_en) begin
      if (pe_first < 0) pe_first = cyc;
      pe_last = cyc;
    end
    if (reg_reset) rr_cyc = cyc;
    if (done) done_cnt++;
  end

  int opa [256];
  int opb [256];

  // Runs one job from IDLE; caller is 1 time unit after a rising edge.
  // gap = bubble cycles between terms; spur = start pulse while busy.
  task automatic run_job(input int k, input logic r, input int gap, input bit spur,
                         output int t0, output int td);
    pe_first = -1; pe_last = -1; rr_cyc = -1;
    start = 1; len = W_LEN'(k); relu = r; op_valid = 0; t0 = cyc;
    @(posedge clk); #1;
    start = 0; op_valid = 1; op_a = W_IN'(opa[0]); op_b = W_IN'(opb[0]);
    @(posedge clk); #1;
    for (int i = 0; i < k; i++) begin
      op_a = W_IN'(opa[i]); op_b = W_IN'(opb[i]); op_valid = 1;
      if (spur && i == 0) begin start = 1; len = 8'd5; relu = ~r; end
      @(posedge clk); #1;
      start = 0;
      if (gap > 0 && i < k - 1) begin
        op_valid = 0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    op_valid = 0;
    td = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin td = cyc; break; end
    end
    chk("done_seen", td >= 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, td, dc;
    reset_n = 0; start = 0; len = 0; relu = 0; op_valid = 0; op_a = 0; op_b = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;
    chk("init_busy", busy, 0);
    chk("init_result", result, 0);

    // Two-term raw job with literal timing.
    opa[0] = 3; opb[0] = -2; opa[1] = 4; opb[1] = 1;
    run_job(2, 0, 0, 0, t0, td);
    chk("j1_reg_reset_cyc", rr_cyc - t0, 1);
    chk("j1_pe_first", pe_first - t0, 2);
    chk("j1_pe_last", pe_last - t0, 3);
    chk("j1_done_cyc", td - t0, 8);
    chk("j1_result", result, -2);

    // ReLU job clamps to zero, then a raw job proves the accumulator clears.
    opa[0] = 8; opb[0] = -3; opa[1] = 2; opb[1] = 1; opa[2] = 10; opb[2] = -5;
    run_job(3, 1, 0, 0, t0, td);
    chk("j2_result", result, 0);
    opa[0] = 1; opb[0] = -1; opa[1] = 10; opb[1] = 1; opa[2] = 10; opb[2] = 1;
    run_job(3, 0, 0, 0, t0, td);
    chk("j3_result", result, 19);

    // Bubbles between terms delay done by the bubble count.
    opa[0] = 3; opb[0] = -2; opa[1] = 4; opb[1] = 1;
    run_job(2, 0, 2, 0, t0, td);
    chk("j4_done_cyc", td - t0, 10);
    chk("j4_result", result, -2);

    // Zero-length start is ignored.
    start = 1; len = 0; relu = 1;
    @(posedge clk); #1;
    start = 0;
    chk("len0_busy", busy, 0);
    chk("len0_mode_sel", mode_sel, 0);

    // Start while busy is ignored.
    opa[0] = 6; opb[0] = 7; opa[1] = 2; opb[1] = -3;
    run_job(2, 0, 0, 1, t0, td);
    chk("spur_done_cyc", td - t0, 8);
    chk("spur_result", result, 36);

    // Asynchronous reset mid-issue abandons the job.
    start = 1; len = 3; relu = 1;
    @(posedge clk); #1;
    start = 0; op_valid = 1; op_a = 7; op_b = 7;
    repeat (2) begin @(posedge clk); #1; end
    #2 reset_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_op_ready", op_ready, 0);
    chk("arst_pe_en", pe_en, 0);
    chk("arst_mode_sel", mode_sel, 0);
    chk("arst_result", result, 0);
    op_valid = 0;
    @(posedge clk); #1 reset_n = 1;
    dc = done_cnt;
    repeat (10) begin @(posedge clk); #1; end
    chk("arst_no_done", done_cnt - dc, 0);
    opa[0] = 5; opb[0] = 5;
    run_job(1, 0, 0, 0, t0, td);
    chk("j5_result", result, 25);

    // Maximum-length job at extreme operands.
    for (int i = 0; i < 255; i++) begin opa[i] = 255; opb[i] = -128; end
    run_job(255, 0, 0, 0, t0, td);
    chk("j6_done_cyc", td - t0, 261);
    chk("j6_result", result, -8323200);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameters: W_IN, default 8, operand width; W_ACC, default 24, pe_core result width; W_LEN, default 8, term-count width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  job request; sampled only in IDLE.
REQ-005 len  input  W_LEN  number of MAC terms K in the job; sampled with start.
REQ-006 relu  input  1  output mode for the job (0 raw, 1 ReLU); sampled with start.
REQ-007 op_valid  input  1  operand pair available.
REQ-008 op_ready  output  1  feeder accepts operand pair this cycle.
REQ-009 op_a  input  W_IN  unsigned activation operand.
REQ-010 op_b  input  W_IN  signed weight operand.
REQ-011 pe_en, mode_sel, reg_reset  output  1 each  pe_core controls.
REQ-012 a_mul  output  W_IN  unsigned operand to pe_core; b_mul  output  W_IN  signed operand to pe_core.
REQ-013 pe_results  input  W_ACC  signed pe_core results.
REQ-014 busy  output  1  job in progress; done  output  1  one-cycle completion pulse; result  output  W_ACC  signed captured job result.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, ISSUE and DRAIN.
REQ-016 IDLE -> CLEAR when start=1 and len!=0; len_q <= len, relu_q <= relu, term counter <= 0.
REQ-017 start with len=0, or any start outside IDLE, SHALL be ignored with no output change.
REQ-018 CLEAR SHALL last exactly one cycle with reg_reset=1 and pe_en=0, then go to ISSUE.
REQ-019 In ISSUE: op_ready=1; pe_en = op_valid; a_mul=op_a and b_mul=op_b combinationally; a handshake SHALL increment the term counter.
REQ-020 In ISSUE, op_valid=0 SHALL give pe_en=0 (bubble) with the counter unchanged.
REQ-021 The handshake that issues term K SHALL move the FSM to DRAIN on the same edge.
REQ-022 DRAIN SHALL last exactly 4 cycles with pe_en=0, reg_reset=0 and op_ready=0.
REQ-023 On the last DRAIN edge: result <= pe_results, done <= 1, FSM -> IDLE.
REQ-024 Timing: last issue in cycle c SHALL give done=1 and a valid result in cycle c+5.
REQ-025 done SHALL be high for exactly one cycle; result SHALL hold until the next done.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 mode_sel SHALL equal relu_q at all times, constant from CLEAR through DRAIN.
REQ-028 Outside ISSUE: pe_en=0 and op_ready=0; reg_reset=1 only in CLEAR.
REQ-029 Outside ISSUE, a_mul/b_mul SHALL still follow op_a/op_b, which is harmless because pe_en=0.
REQ-030 The term counter SHALL be W_LEN bits and SHALL NOT wrap; K=2^W_LEN-1 is the maximum job.

Reset
REQ-031 reset_n=0 SHALL immediately (asynchronously) force IDLE and zero all of: pe_en, reg_reset, mode_sel, op_ready, busy, done, result, counters, len_q, relu_q.
REQ-032 Reset mid-job SHALL abandon the job with no done; the next job SHALL start with CLEAR, so no stale accumulation leaks.

Verification
REQ-033 Cycle 0 start with len=2, relu=0; operands (3,-2),(4,1) with op_valid held high -> reg_reset in cycle 1, pe_en in cycles 2-3, done in cycle 8, result=-2.
REQ-034 Job relu=1, operands (8,-3),(2,1),(10,-5) -> result=0; then job relu=0, operands (1,-1),(10,1),(10,1) -> result=19, proving the clear between jobs.
REQ-035 Repeat REQ-033 with op_valid low for 2 cycles between terms -> pe_en low in those cycles, result=-2, done 2 cycles later.
REQ-036 start with len=0 in IDLE, and start while busy -> no state change, busy and done unaffected.
REQ-037 reset_n low during ISSUE -> all outputs 0 at once, no done; next job (5,5) with len=1 -> result=25.
REQ-038 len=255, every operand (255,-128) -> result=-8323200, no overflow.
